pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive side of the PWM interface: samples an external PWM line and measures its high time and period in units of `step` ticks.
- Reports the measurement as a `duty` code compatible with the generator's `duty` input. Driving this block from a generator at the same N and `step` rate returns the programmed `duty` value.
- Used for loopback checks and for reading PWM-style sensors and knobs into the etch-a-sketch datapath.

Parameters:
- N, 8, width of the `duty`/`period` measurements; nominal PWM period is 2^N `step` ticks.
- SYNC_STAGES, 2, number of synchronizer flops on `pwm_in`; legal values are 2 or 3.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately.
- ena  input  1  measurement enable; when low, counters hold and no results are produced.
- step  input  1  tick qualifier; counters advance only on cycles with `step`=1.
- pwm_in  input  1  asynchronous PWM line to be measured.
- duty  output  N  last measured high-time count, in `step` ticks (saturating).
- period  output  N  last measured period count minus 1, in `step` ticks (saturating).
- valid  output  1  one-cycle pulse when `duty`/`period` update.
- steady  output  1  high while the last result came from a timeout (constant line) rather than edges.

Behaviour:
- **Reset** (rst=0, asynchronous): synchronizer flops, FSM, counters, `duty`, `period`, `valid` and `steady` all go to 0; FSM enters SEEK. Reset release is sampled on clk.
- **Input conditioning:** `pwm_in` passes through SYNC_STAGES flops. `s` is the last synchronizer flop; `s_d` is `s` delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Edges are detected on every clk, independent of `step`.
  - Latency from a `pwm_in` transition to its edge being seen is SYNC_STAGES+1 clk.
- **Counters:** `hi_cnt` and `per_cnt`, N bits each.
  - Increment by 1 on a cycle with ena & step.
  - Saturate at 2^N-1; they never wrap.
  - `hi_cnt` increments only while s=1.
- **FSM states:**
  - SEEK: counters held at 0. On rise go to HIGH, with both counters at 0.
  - HIGH: count `per_cnt` and `hi_cnt`. On fall go to LOW.
  - LOW: count `per_cnt` only. On rise:
    - latch `duty` <= `hi_cnt`, `period` <= `per_cnt`;
    - `valid`=1 for one cycle; `steady` <= 0;
    - clear both counters; go to HIGH.
- **Same-cycle step and edge:** when a rise in LOW coincides with ena & step, the latched values exclude that step's increment. The new period's counters start at 0; the step is not lost to the new period.
- **Timeout:** in HIGH, LOW or SEEK, a timeout occurs when `per_cnt` is saturated and another ena & step arrives with no edge. SEEK needs its own saturating counter, or reuse of `per_cnt`; either implementation is acceptable.
  - On timeout, latch `duty` <= (s ? 2^N-1 : 0) and `period` <= 2^N-1.
  - `steady` <= 1; pulse `valid`; clear counters.
  - Next state: SEEK if s=0, HIGH if s=1, so a constant-high line re-reports every 2^N ticks.
  - Once in timeout, `valid` pulses once every 2^N ena & step ticks for as long as the line stays constant.
- **Duty saturation:** a 100%-high line always reports `duty`=2^N-1. A 0% line always reports `duty`=0. This matches the generator's full-off and full-on endpoints.
- **ena=0:**
  - FSM state and counters hold.
  - Edges still update `s`/`s_d` but are ignored by the FSM.
  - When ena returns, the first partial period is discarded: the FSM is forced to SEEK on the ena rising transition.
- **Output stability:** `duty`, `period` and `steady` change only on the `valid` cycle; otherwise they hold.
- **Mid-operation reset:** all outputs clear asynchronously; no `valid` is generated for the interrupted period.
- **Glitches:** no debouncing. Every synchronized edge counts, including single-clk pulses.

Test Plan:
1. Generator-style stimulus, N=8, step every clk, line high 64 ticks / low 192 ticks, repeated → from the 2nd rise on, `valid` once per 256 ticks with `duty`=64, `period`=255, `steady`=0.
2. Step every 4th clk, high 10 steps / low 6 steps → `duty`=10, `period`=15. Verify rise-to-`valid` latency is SYNC_STAGES+1 clk.
3. Hold `pwm_in`=1 for 1000 steps after reset → first `valid` at `per_cnt` saturation, with `duty`=255, `period`=255, `steady`=1; repeats every 256 steps. Then drive `pwm_in`=0 → `duty`=0 on the next timeout.
4. Run pattern 1, deassert ena for 300 clk mid-LOW, reassert → no `valid` during ena=0 or for the partial period; the first `valid` after the second rise shows `duty`=64.
5. Assert rst low asynchronously mid-HIGH (not on a clk edge) → all outputs 0 immediately. After release, first `valid` comes only after a full period.
6. 1-clk-wide high pulse every 256 ticks, with step coinciding with the pulse → `duty` is 0 or 1 per the same-cycle rule; verify `period`=255 and no missed edges.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM receive side: synchronizes an external PWM line and measures its high time and
// period (minus one) in step ticks; a constant line is reported via timeout.
module pwm_capture #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         step,
  input  logic         pwm_in,
  output logic [N-1:0] duty,
  output logic [N-1:0] period,
  output logic         valid,
  output logic         steady
);

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [N-1:0] CNT_MAX  = {N{1'b1}};
  localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
  localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

  function automatic logic [N-1:0] sat_inc(input logic [N-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   r_ena_d;
  state_t                 r_state;
  logic [N-1:0]           r_hi_cnt;
  logic [N-1:0]           r_per_cnt;
  logic [N-1:0]           r_duty;
  logic [N-1:0]           r_period;
  logic                   r_valid;
  logic                   r_steady;

  logic w_s;
  logic w_rise;
  logic w_fall;
  logic w_tick;
  logic w_ena_rise;
  logic w_timeout;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_rise     = w_s & ~r_s_d;
  assign w_fall     = ~w_s & r_s_d;
  assign w_tick     = ena & step;
  assign w_ena_rise = ena & ~r_ena_d;
  assign w_timeout  = w_tick & (r_per_cnt == CNT_MAX) & ~w_rise & ~w_fall;

  // Input synchronizer, edge-detect delay and enable history run on every clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= '0;
      r_s_d   <= 1'b0;
      r_ena_d <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      end else begin
        r_sync <= pwm_in;
      end
      r_s_d   <= w_s;
      r_ena_d <= ena;
    end
  end

  // Measurement FSM with counters and registered results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= SEEK;
      r_hi_cnt  <= CNT_ZERO;
      r_per_cnt <= CNT_ZERO;
      r_duty    <= CNT_ZERO;
      r_period  <= CNT_ZERO;
      r_valid   <= 1'b0;
      r_steady  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_ena_rise) begin
        // A period interrupted by ena=0 is partial; restart the search.
        r_state   <= SEEK;
        r_hi_cnt  <= CNT_ZERO;
        r_per_cnt <= CNT_ZERO;
      end else if (ena) begin
        if (w_timeout) begin
          r_duty    <= w_s ? CNT_MAX : CNT_ZERO;
          r_period  <= CNT_MAX;
          r_steady  <= 1'b1;
          r_valid   <= 1'b1;
          r_hi_cnt  <= CNT_ZERO;
          r_per_cnt <= CNT_ZERO;
          r_state   <= w_s ? HIGH : SEEK;
        end else begin
          case (r_state)
            SEEK: begin
              if (w_rise) begin
                r_state   <= HIGH;
                r_hi_cnt  <= w_tick ? CNT_ONE : CNT_ZERO;
                r_per_cnt <= CNT_ZERO;
              end else if (w_tick) begin
                r_per_cnt <= sat_inc(r_per_cnt);
              end
            end
            HIGH: begin
              if (w_tick) begin
                r_per_cnt <= sat_inc(r_per_cnt);
                if (w_s) begin
                  r_hi_cnt <= sat_inc(r_hi_cnt);
                end
              end
              if (w_fall) begin
                r_state <= LOW;
              end
            end
            LOW: begin
              if (w_rise) begin
                // The rising step opens the next period: tick 0 of it, and high time 1.
                r_duty    <= r_hi_cnt;
                r_period  <= r_per_cnt;
                r_steady  <= 1'b0;
                r_valid   <= 1'b1;
                r_hi_cnt  <= w_tick ? CNT_ONE : CNT_ZERO;
                r_per_cnt <= CNT_ZERO;
                r_state   <= HIGH;
              end else if (w_tick) begin
                r_per_cnt <= sat_inc(r_per_cnt);
              end
            end
            default: begin
              r_state   <= SEEK;
              r_hi_cnt  <= CNT_ZERO;
              r_per_cnt <= CNT_ZERO;
            end
          endcase
        end
      end
    end
  end

  assign duty   = r_duty;
  assign period = r_period;
  assign valid  = r_valid;
  assign steady = r_steady;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed scenarios plus a randomized waveform
// compared against an array-based model of high-time and period counting.
module tb_pwm_capture;

  localparam int N = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ena = 1'b0;
  logic         step = 1'b0;
  logic         pwm_in = 1'b0;
  logic [N-1:0] duty;
  logic [N-1:0] period;
  logic         valid;
  logic         steady;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [N-1:0] q_duty[$];
  logic [N-1:0] q_per[$];
  logic         q_st[$];
  int           q_cyc[$];

  pwm_capture #(.N(N), .SYNC_STAGES(S)) dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .step   (step),
    .pwm_in (pwm_in),
    .duty   (duty),
    .period (period),
    .valid  (valid),
    .steady (steady)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      q_duty.push_back(duty);
      q_per.push_back(period);
      q_st.push_back(steady);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    q_duty.delete();
    q_per.delete();
    q_st.delete();
    q_cyc.delete();
  endtask

  // div = 0: random step; div > 0: step on cycles where cyc % div == 0
  task automatic drive(input logic lvl, input logic en, input int n, input int div);
    repeat (n) begin
      @(posedge clk);
      #1;
      pwm_in = lvl;
      ena    = en;
      if (div == 0) step = ($urandom_range(0, 1) == 1);
      else          step = ((cyc % div) == 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ena = 1'b1;
    pwm_in = 1'b0;
    step = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    clear_q();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ena = 1'b1;
    step = 1'b1;
    pwm_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++; if (duty !== 8'd0)   begin bad++; $display("FAIL reset_duty: got %0d want 0", duty); end
    total++; if (period !== 8'd0) begin bad++; $display("FAIL reset_period: got %0d want 0", period); end
    total++; if (valid !== 1'b0)  begin bad++; $display("FAIL reset_valid: got %0b want 0", valid); end
    total++; if (steady !== 1'b0) begin bad++; $display("FAIL reset_steady: got %0b want 0", steady); end
  endtask

  task automatic test_generator();
    do_reset();
    drive(1'b0, 1'b1, 4, 1);
    repeat (4) begin
      drive(1'b1, 1'b1, 64, 1);
      drive(1'b0, 1'b1, 192, 1);
    end
    drive(1'b1, 1'b1, S + 4, 1);
    total++; if (q_duty.size() !== 4) begin bad++; $display("FAIL gen_count: got %0d want 4", q_duty.size()); end
    for (int i = 0; i < q_duty.size(); i++) begin
      total++; if (q_duty[i] !== 8'd64)  begin bad++; $display("FAIL gen_duty[%0d]: got %0d want 64", i, q_duty[i]); end
      total++; if (q_per[i] !== 8'd255)  begin bad++; $display("FAIL gen_period[%0d]: got %0d want 255", i, q_per[i]); end
      total++; if (q_st[i] !== 1'b0)     begin bad++; $display("FAIL gen_steady[%0d]: got %0b want 0", i, q_st[i]); end
      if (i > 0) begin
        total++; if (q_cyc[i] - q_cyc[i-1] != 256) begin bad++; $display("FAIL gen_spacing[%0d]: got %0d want 256", i, q_cyc[i] - q_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_step4();
    int rise_c[5];
    do_reset();
    drive(1'b0, 1'b1, 4, 4);
    while (((cyc + 1 + S) % 4) != 0) drive(1'b0, 1'b1, 1, 4);
    for (int k = 0; k < 4; k++) begin
      rise_c[k] = cyc + 1;
      drive(1'b1, 1'b1, 40, 4);
      drive(1'b0, 1'b1, 24, 4);
    end
    rise_c[4] = cyc + 1;
    drive(1'b1, 1'b1, S + 4, 4);
    total++; if (q_duty.size() !== 4) begin bad++; $display("FAIL step4_count: got %0d want 4", q_duty.size()); end
    for (int i = 0; i < q_duty.size() && i < 4; i++) begin
      total++; if (q_duty[i] !== 8'd10) begin bad++; $display("FAIL step4_duty[%0d]: got %0d want 10", i, q_duty[i]); end
      total++; if (q_per[i] !== 8'd15)  begin bad++; $display("FAIL step4_period[%0d]: got %0d want 15", i, q_per[i]); end
      total++; if (q_cyc[i] - rise_c[i+1] != S + 1) begin bad++; $display("FAIL step4_latency[%0d]: got %0d want %0d", i, q_cyc[i] - rise_c[i+1], S + 1); end
    end
  endtask

  task automatic test_steady();
    rst = 1'b0;
    ena = 1'b1;
    step = 1'b1;
    pwm_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    clear_q();
    drive(1'b1, 1'b1, 1000, 1);
    total++; if (q_duty.size() !== 3) begin bad++; $display("FAIL steady_count: got %0d want 3", q_duty.size()); end
    for (int i = 0; i < q_duty.size(); i++) begin
      total++; if (q_duty[i] !== 8'd255) begin bad++; $display("FAIL steady_duty[%0d]: got %0d want 255", i, q_duty[i]); end
      total++; if (q_per[i] !== 8'd255)  begin bad++; $display("FAIL steady_period[%0d]: got %0d want 255", i, q_per[i]); end
      total++; if (q_st[i] !== 1'b1)     begin bad++; $display("FAIL steady_flag[%0d]: got %0b want 1", i, q_st[i]); end
      if (i > 0) begin
        total++; if (q_cyc[i] - q_cyc[i-1] != 256) begin bad++; $display("FAIL steady_spacing[%0d]: got %0d want 256", i, q_cyc[i] - q_cyc[i-1]); end
      end
    end
    clear_q();
    drive(1'b0, 1'b1, 300, 1);
    total++; if (q_duty.size() < 1) begin bad++; $display("FAIL low_count: got %0d want >=1", q_duty.size()); end
    if (q_duty.size() > 0) begin
      total++; if (q_duty[0] !== 8'd0)  begin bad++; $display("FAIL low_duty: got %0d want 0", q_duty[0]); end
      total++; if (q_per[0] !== 8'd255) begin bad++; $display("FAIL low_period: got %0d want 255", q_per[0]); end
      total++; if (q_st[0] !== 1'b1)    begin bad++; $display("FAIL low_steady: got %0b want 1", q_st[0]); end
    end
  endtask

  task automatic test_ena_gap();
    do_reset();
    drive(1'b0, 1'b1, 4, 1);
    repeat (2) begin
      drive(1'b1, 1'b1, 64, 1);
      drive(1'b0, 1'b1, 192, 1);
    end
    drive(1'b1, 1'b1, 64, 1);
    drive(1'b0, 1'b1, 50, 1);
    clear_q();
    drive(1'b0, 1'b0, 300, 1);
    drive(1'b0, 1'b1, 142, 1);
    drive(1'b1, 1'b1, 64, 1);
    drive(1'b0, 1'b1, 192, 1);
    total++; if (q_duty.size() !== 0) begin bad++; $display("FAIL ena_gap_quiet: got %0d want 0", q_duty.size()); end
    drive(1'b1, 1'b1, S + 4, 1);
    total++; if (q_duty.size() !== 1) begin bad++; $display("FAIL ena_count: got %0d want 1", q_duty.size()); end
    if (q_duty.size() > 0) begin
      total++; if (q_duty[0] !== 8'd64) begin bad++; $display("FAIL ena_duty: got %0d want 64", q_duty[0]); end
      total++; if (q_per[0] !== 8'd255) begin bad++; $display("FAIL ena_period: got %0d want 255", q_per[0]); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b0, 1'b1, 4, 1);
    repeat (2) begin
      drive(1'b1, 1'b1, 64, 1);
      drive(1'b0, 1'b1, 192, 1);
    end
    drive(1'b1, 1'b1, 20, 1);
    #3 rst = 1'b0;
    #1;
    total++; if (duty !== 8'd0)   begin bad++; $display("FAIL arst_duty: got %0d want 0", duty); end
    total++; if (period !== 8'd0) begin bad++; $display("FAIL arst_period: got %0d want 0", period); end
    total++; if (valid !== 1'b0)  begin bad++; $display("FAIL arst_valid: got %0b want 0", valid); end
    drive(1'b1, 1'b1, 44, 1);
    drive(1'b0, 1'b1, 10, 1);
    rst = 1'b1;
    clear_q();
    drive(1'b0, 1'b1, 182, 1);
    drive(1'b1, 1'b1, 64, 1);
    drive(1'b0, 1'b1, 192, 1);
    total++; if (q_duty.size() !== 0) begin bad++; $display("FAIL arst_quiet: got %0d want 0", q_duty.size()); end
    drive(1'b1, 1'b1, S + 4, 1);
    total++; if (q_duty.size() !== 1) begin bad++; $display("FAIL arst_count: got %0d want 1", q_duty.size()); end
    if (q_duty.size() > 0) begin
      total++; if (q_duty[0] !== 8'd64) begin bad++; $display("FAIL arst_meas_duty: got %0d want 64", q_duty[0]); end
    end
  endtask

  task automatic test_pulse();
    do_reset();
    drive(1'b0, 1'b1, 4, 1);
    repeat (5) begin
      drive(1'b1, 1'b1, 1, 1);
      drive(1'b0, 1'b1, 255, 1);
    end
    drive(1'b1, 1'b1, S + 4, 1);
    total++; if (q_duty.size() !== 5) begin bad++; $display("FAIL pulse_count: got %0d want 5", q_duty.size()); end
    for (int i = 0; i < q_duty.size(); i++) begin
      total++; if (q_duty[i] !== 8'd1)  begin bad++; $display("FAIL pulse_duty[%0d]: got %0d want 1", i, q_duty[i]); end
      total++; if (q_per[i] !== 8'd255) begin bad++; $display("FAIL pulse_period[%0d]: got %0d want 255", i, q_per[i]); end
    end
  endtask

  // Model: high time = steps seen while the synchronized line is high from one
  // synchronized rise (inclusive) to the next (exclusive); period = steps strictly
  // between the two rises. Both saturate at 255.
  task automatic test_random();
    logic lv[$];
    logic st[$];
    int   rises[$];
    int   exp_d[$];
    int   exp_p[$];
    int   d;
    int   p;
    do_reset();
    repeat (3) lv.push_back(1'b0);
    repeat (6) begin
      int h = $urandom_range(1, 120);
      int l = $urandom_range(1, 120);
      repeat (h) lv.push_back(1'b1);
      repeat (l) lv.push_back(1'b0);
    end
    repeat (S + 4) lv.push_back(1'b1);
    for (int t = 0; t < lv.size(); t++) st.push_back($urandom_range(0, 1) == 1);
    for (int j = 1; j < lv.size(); j++) if (lv[j] && !lv[j-1]) rises.push_back(j);
    for (int k = 1; k < rises.size(); k++) begin
      d = 0;
      p = 0;
      for (int u = rises[k-1] + S; u < rises[k] + S; u++) if (st[u] && lv[u-S]) d++;
      for (int u = rises[k-1] + S + 1; u < rises[k] + S; u++) if (st[u]) p++;
      exp_d.push_back(d > 255 ? 255 : d);
      exp_p.push_back(p > 255 ? 255 : p);
    end
    for (int t = 0; t < lv.size(); t++) begin
      @(posedge clk);
      #1;
      pwm_in = lv[t];
      step   = st[t];
    end
    total++; if (q_duty.size() !== exp_d.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", q_duty.size(), exp_d.size()); end
    for (int i = 0; i < q_duty.size() && i < exp_d.size(); i++) begin
      total++; if (int'(q_duty[i]) != exp_d[i]) begin bad++; $display("FAIL rand_duty[%0d]: got %0d want %0d", i, q_duty[i], exp_d[i]); end
      total++; if (int'(q_per[i]) != exp_p[i])  begin bad++; $display("FAIL rand_period[%0d]: got %0d want %0d", i, q_per[i], exp_p[i]); end
      total++; if (q_st[i] !== 1'b0)            begin bad++; $display("FAIL rand_steady[%0d]: got %0b want 0", i, q_st[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_generator();
    test_step4();
    test_steady();
    test_ena_gap();
    test_async_reset();
    test_pulse();
    repeat (3) test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
